// File: rtl/alu_acc_sequencer.sv
// Command-driven accumulator sequencer wrapped around a 4-bit ALU.
// Optional macro SHIFT_THROUGH_CARRY_EN: shifts rotate through the carry flag.
module alu_acc_sequencer #(
    parameter int W     = 4,
    parameter int REP_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_cin,
    input  logic             cmd_ld,
    input  logic [W-1:0]     cmd_data,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_s0,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic             alu_s3,
    output logic             alu_c0,
    output logic             alu_il,
    output logic             alu_ir,
    input  logic [W-1:0]     alu_f,
    input  logic             alu_c8,
    output logic [W-1:0]     acc,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             carry_q, carry_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        rep_d   = rep_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ld) begin
                        acc_d   = cmd_data;
                        carry_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        b_d     = cmd_data;
                        op_d    = cmd_op;
                        cin_d   = cmd_cin;
                        rep_d   = cmd_rep;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d = alu_f;
                if (!op_q[3] && !op_q[2]) begin
                    carry_d = alu_c8;
                end
`ifdef SHIFT_THROUGH_CARRY_EN
                else if (op_q[3]) begin
                    // Capture the bit leaving the accumulator: 5-bit rotate.
                    carry_d = op_q[2] ? acc_q[0] : acc_q[W-1];
                end
`endif
                if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            rep_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            rep_q   <= rep_d;
            carry_q <= carry_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_s0    = op_q[0];
    assign alu_s1    = op_q[1];
    assign alu_s2    = op_q[2];
    assign alu_s3    = op_q[3];
    assign alu_c0    = cin_q;
`ifdef SHIFT_THROUGH_CARRY_EN
    assign alu_il    = carry_q;
    assign alu_ir    = carry_q;
`else
    assign alu_il    = 1'b0;
    assign alu_ir    = 1'b0;
`endif
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign zero      = (acc_q == '0);

endmodule
